// File: rtl/wb_master_pkg.sv
// Shared definitions for the single-outstanding WISHBONE initiator:
// FSM state encoding, default geometry/timeout and the error read value.
package wb_master_pkg;

    // FSM state encoding (kept as plain constants for legacy tools)
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] BUS   = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam int WB_AW_DEFAULT      = 2;
    localparam int WB_DW_DEFAULT      = 8;
    localparam int WB_TIMEOUT_DEFAULT = 15;

    // Data returned on a timed-out cycle; wide enough to be truncated to any DW up to 64
    localparam logic [63:0] WB_ERR_DATA = '1;

endpackage

// File: rtl/wb_master_if.sv
// Command/response stream plus WISHBONE bus signals of wb_master.
// The master modport is the initiator's view; slave is the view of the
// surrounding environment (command source, response sink, register slaves).
interface wb_master_if
    import wb_master_pkg::*;
#(
    parameter int AW = WB_AW_DEFAULT,
    parameter int DW = WB_DW_DEFAULT
);
    // command stream
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;

    // response stream
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_dat;
    logic          rsp_err;

    // WISHBONE side
    logic          cyc_o;
    logic          stb_o;
    logic          we_o;
    logic [AW-1:0] adr_o;
    logic [DW-1:0] dat_o;
    logic [DW-1:0] dat_i;
    logic          ack_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, rsp_ready, dat_i, ack_i,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err,
        output cyc_o, stb_o, we_o, adr_o, dat_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, rsp_ready, dat_i, ack_i,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
        input  cyc_o, stb_o, we_o, adr_o, dat_o
    );

endinterface

// File: rtl/wb_master.sv
// Single-outstanding WISHBONE initiator. Each accepted command becomes one
// classic WISHBONE cycle preceded by a one-cycle address setup phase, so
// registered-read slaves have valid data by the time they ack. A missing
// ack is turned into an error response after TIMEOUT bus cycles.
// The interface instance must be built with the same AW/DW as this module.
module wb_master
    import wb_master_pkg::*;
#(
    parameter int AW      = WB_AW_DEFAULT,
    parameter int DW      = WB_DW_DEFAULT,
    parameter int TIMEOUT = WB_TIMEOUT_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    wb_master_if.master wb
);

    // Counter only ever reaches TIMEOUT-1, so it cannot wrap
    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(TIMEOUT - 1);

    logic [1:0]    state_reg;
    logic [1:0]    state_next;
    logic [CW-1:0] count_reg;

    logic accept;
    logic ack_hit;
    logic tmo_hit;
    logic rsp_take;

    // Only IDLE takes commands; anything offered elsewhere simply waits
    assign wb.cmd_ready = (state_reg == IDLE);

    // Event decode and next-state selection
    always_comb begin
        accept   = (state_reg == IDLE) && wb.cmd_valid;
        ack_hit  = (state_reg == BUS) && wb.ack_i;
        // an ack in the final allowed cycle wins over the timeout
        tmo_hit  = (state_reg == BUS) && !wb.ack_i && (count_reg == LAST_CNT);
        rsp_take = (state_reg == RESP) && wb.rsp_ready;

        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = SETUP;
            SETUP:   state_next = BUS;
            BUS:     if (ack_hit || tmo_hit) state_next = RESP;
            RESP:    if (rsp_take) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // WISHBONE outputs: latch command, raise cyc/stb after setup, drop on completion
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wb.cyc_o <= 1'b0;
            wb.stb_o <= 1'b0;
            wb.we_o  <= 1'b0;
            wb.adr_o <= '0;
            wb.dat_o <= '0;
        end else if (accept) begin
            wb.we_o  <= wb.cmd_we;
            wb.adr_o <= wb.cmd_adr;
            wb.dat_o <= wb.cmd_dat;
        end else if (state_reg == SETUP) begin
            wb.cyc_o <= 1'b1;
            wb.stb_o <= 1'b1;
        end else if (ack_hit || tmo_hit) begin
            // adr_o/dat_o deliberately keep their last values
            wb.cyc_o <= 1'b0;
            wb.stb_o <= 1'b0;
            wb.we_o  <= 1'b0;
        end
    end

    // Response register: captured at bus completion, held until consumed
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wb.rsp_valid <= 1'b0;
            wb.rsp_dat   <= '0;
            wb.rsp_err   <= 1'b0;
        end else if (ack_hit) begin
            wb.rsp_valid <= 1'b1;
            wb.rsp_dat   <= wb.we_o ? '0 : wb.dat_i;
            wb.rsp_err   <= 1'b0;
        end else if (tmo_hit) begin
            wb.rsp_valid <= 1'b1;
            wb.rsp_dat   <= DW'(WB_ERR_DATA);
            wb.rsp_err   <= 1'b1;
        end else if (rsp_take) begin
            wb.rsp_valid <= 1'b0;
        end
    end

    // Bus-phase cycle counter, cleared when the response is consumed
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_reg <= '0;
        end else if (rsp_take) begin
            count_reg <= '0;
        end else if ((state_reg == BUS) && !wb.ack_i && !tmo_hit) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_master.sv
// Scoreboard bench for wb_master: a register-slave model with a registered
// read path and programmable wait states, a driver that pushes expected
// responses on command acceptance, and a monitor that checks responses,
// latency, bus-phase length and handshake rules.
module tb_wb_master;
    import wb_master_pkg::*;

    localparam int AW  = 2;
    localparam int DW  = 8;
    localparam int TMO = 4;

    logic clk   = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk = ~clk;

    wb_master_if #(.AW(AW), .DW(DW)) bus ();

    wb_master #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .wb    (bus)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic          err;
        int            acc_edge;
        int            lat;
        int            stb_cycles;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;
    int   edge_cnt = 0;

    logic [DW-1:0] model_regs [4];
    logic [DW-1:0] slave_regs [4];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- register slave model ----------------
    int            wait_cfg  = 0;
    int            bus_cnt   = 0;
    logic [DW-1:0] rd_reg;
    logic          stray_ack = 1'b0;
    bit            stray_en  = 1'b0;

    always @(posedge clk) begin
        if (bus.cyc_o && bus.stb_o) bus_cnt <= bus_cnt + 1;
        else                        bus_cnt <= 0;
        rd_reg <= slave_regs[bus.adr_o];
        if (bus.cyc_o && bus.stb_o && bus.ack_i && bus.we_o)
            slave_regs[bus.adr_o] <= bus.dat_o;
    end

    always_comb begin
        bus.ack_i = (bus.cyc_o && bus.stb_o && (bus_cnt == wait_cfg)) || stray_ack;
        bus.dat_i = rd_reg;
    end

    // ---------------- response consumer / stray ack source ----------------
    int hold       = 0;
    bit rand_ready = 1'b0;

    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid && hold > 0) begin
                bus.rsp_ready = 1'b0;
                hold--;
            end else begin
                bus.rsp_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            stray_ack = stray_en && !bus.cyc_o && ($urandom_range(0, 1) == 1);
        end
    end

    // ---------------- driver ----------------
    task automatic do_cmd(input logic we, input logic [AW-1:0] adr,
                          input logic [DW-1:0] dat, input int w);
        exp_t e;
        bit   accepted = 1'b0;
        int   bus_len;
        bus.cmd_we    = we;
        bus.cmd_adr   = adr;
        bus.cmd_dat   = dat;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            check("accept_timeout", 32'd0, 32'd1);
            return;
        end
        #1;
        // reference: an ack after w wait cycles, or a timeout after TMO cycles
        bus_len      = (w < TMO) ? w + 1 : TMO;
        e.we         = we;
        e.adr        = adr;
        e.acc_edge   = edge_cnt + 1;
        e.lat        = bus_len + 1;
        e.stb_cycles = bus_len;
        if (w >= TMO) begin
            e.dat = '1;
            e.err = 1'b1;
        end else if (we) begin
            model_regs[adr] = dat;
            e.dat = '0;
            e.err = 1'b0;
        end else begin
            e.dat = model_regs[adr];
            e.err = 1'b0;
        end
        wait_cfg = w;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.rsp_valid) return;
        end
        check("drain_timeout", exp_q.size(), 32'd0);
    endtask

    // ---------------- monitor ----------------
    bit            mon_en = 1'b0;
    logic          prev_rv, prev_rr, prev_stb, prev_cyc, prev_err;
    logic [DW-1:0] prev_dat;
    logic [AW-1:0] prev_adr;
    int            stb_cnt, cyc_rises;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_i || !mon_en) begin
                prev_rv = 0; prev_rr = 0; prev_stb = 0; prev_cyc = 0;
                prev_err = 0; prev_dat = '0; prev_adr = '0;
                stb_cnt = 0; cyc_rises = 0;
            end else begin
                if (bus.cmd_ready)
                    check("idle_clean", {29'd0, exp_q.size() == 0, bus.rsp_valid, bus.cyc_o}, 32'b100);
                if (bus.stb_o) begin
                    stb_cnt++;
                    if (!prev_stb) begin
                        if (exp_q.size() == 0) check("stb_without_cmd", 32'd1, 32'd0);
                        else check("setup_adr", {29'd0, prev_cyc, prev_adr == bus.adr_o,
                                   bus.adr_o == exp_q[0].adr}, 32'b011);
                    end
                end
                if (bus.cyc_o && !prev_cyc) cyc_rises++;
                if (bus.rsp_valid && !prev_rv) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        check("latency", edge_cnt - exp_q[0].acc_edge, exp_q[0].lat);
                        check("stb_cycles", stb_cnt, exp_q[0].stb_cycles);
                        check("cyc_pulses", cyc_rises, 32'd1);
                    end
                    stb_cnt   = 0;
                    cyc_rises = 0;
                end
                if (bus.rsp_valid && prev_rv && !prev_rr)
                    check("rsp_hold", {bus.rsp_err, bus.rsp_dat}, {prev_err, prev_dat});
                if (bus.rsp_valid && bus.rsp_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rsp_dat", bus.rsp_dat, e.dat);
                    check("rsp_err", bus.rsp_err, e.err);
                    n_txn++;
                    $display("txn %0d: we=%0d adr=%0d rsp_dat=0x%02h (exp 0x%02h) rsp_err=%0d (exp %0d)",
                             n_txn, e.we, e.adr, bus.rsp_dat, e.dat, bus.rsp_err, e.err);
                end
                prev_rv  = bus.rsp_valid;
                prev_rr  = bus.rsp_ready;
                prev_stb = bus.stb_o;
                prev_cyc = bus.cyc_o;
                prev_err = bus.rsp_err;
                prev_dat = bus.rsp_dat;
                prev_adr = bus.adr_o;
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        bit seen_cyc;
        for (int i = 0; i < 4; i++) begin
            model_regs[i] = DW'(8'h11 * (i + 1));
            slave_regs[i] = DW'(8'h11 * (i + 1));
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = '0;
        bus.cmd_dat   = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cyc",       bus.cyc_o,     32'd0);
        check("rst_stb",       bus.stb_o,     32'd0);
        check("rst_we",        bus.we_o,      32'd0);
        check("rst_adr",       bus.adr_o,     32'd0);
        check("rst_dat",       bus.dat_o,     32'd0);
        check("rst_rsp_valid", bus.rsp_valid, 32'd0);
        check("rst_rsp_dat",   bus.rsp_dat,   32'd0);
        check("rst_rsp_err",   bus.rsp_err,   32'd0);
        check("rst_cmd_ready", bus.cmd_ready, 32'd1);
        rst_i    = 1'b1;
        mon_en   = 1'b1;
        stray_en = 1'b1;

        // write then read back, registered-read back-to-back reads
        do_cmd(1'b1, 2'd0, 8'hA5, 0);
        do_cmd(1'b0, 2'd0, 8'h00, 0);
        do_cmd(1'b1, 2'd2, 8'h3C, 1);
        do_cmd(1'b0, 2'd2, 8'h00, 0);
        do_cmd(1'b0, 2'd2, 8'h00, 2);
        // timeout, then ack on the last allowed cycle
        do_cmd(1'b0, 2'd1, 8'h00, 10);
        do_cmd(1'b0, 2'd2, 8'h00, TMO - 1);
        do_cmd(1'b1, 2'd1, 8'h77, TMO);
        do_cmd(1'b0, 2'd1, 8'h00, TMO - 1);
        // backpressure: response held off for 5 cycles, next command waiting
        do_cmd(1'b0, 2'd0, 8'h00, 0);
        hold = 5;
        do_cmd(1'b1, 2'd3, 8'hC3, 0);
        bus.cmd_valid = 1'b0;
        drain();

        // reset during BUS
        mon_en = 1'b0;
        do_cmd(1'b0, 2'd3, 8'h00, 20);
        bus.cmd_valid = 1'b0;
        seen_cyc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.cyc_o) begin
                seen_cyc = 1'b1;
                break;
            end
        end
        check("reset_test_in_bus", seen_cyc, 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        check("async_rst_cyc_stb", {bus.cyc_o, bus.stb_o}, 32'd0);
        check("async_rst_rsp_valid", bus.rsp_valid, 32'd0);
        check("async_rst_cmd_ready", bus.cmd_ready, 32'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_i  = 1'b1;
        mon_en = 1'b1;
        do_cmd(1'b1, 2'd3, 8'h5A, 0);
        do_cmd(1'b0, 2'd3, 8'h00, 1);

        // randomized traffic with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            do_cmd(1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)),
                   DW'($urandom), $urandom_range(0, 5));
        end
        bus.cmd_valid = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wb_master.md
# wb_master

Single-outstanding 8-bit WISHBONE initiator that turns a valid/ready command stream (read/write, address, data) into classic single WISHBONE cycles toward the local register slaves (GPIO, instruction-base, etc.) and returns one response per command. It sits between the control front-end (command parser/sequencer) and the local register bus. Every bus cycle gets a one-cycle address setup phase, so slaves with a registered read path return valid data when they assert ack. A bus-phase timeout turns a missing ack into an error response.

## Interface
- AW, 2: address width
- DW, 8: data width
- TIMEOUT, 15: maximum BUS-state cycles waiting for ack; must be ≥1
- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  reset, asynchronous, active low
- cmd_valid  in  1  command present
- cmd_ready  out  1  block accepts command (IDLE only)
- cmd_we  in  1  1=write, 0=read
- cmd_adr  in  AW  register address
- cmd_dat  in  DW  write data (ignored for reads)
- rsp_valid  out  1  response present; held until accepted
- rsp_ready  in  1  consumer accepts response
- rsp_dat  out  DW  read data; 0 for writes; all-ones on timeout
- rsp_err  out  1  1=timeout, no ack received
- cyc_o  out  1  WISHBONE cycle
- stb_o  out  1  WISHBONE strobe
- we_o  out  1  WISHBONE write enable
- adr_o  out  AW  WISHBONE address
- dat_o  out  DW  WISHBONE write data
- dat_i  in  DW  WISHBONE read data
- ack_i  in  1  WISHBONE acknowledge (may be combinational from cyc&stb)

## Operation
- All outputs are registered, except cmd_ready, which is decoded from state == IDLE.
- Reset values: cyc_o=0, stb_o=0, we_o=0, adr_o=0, dat_o=0, rsp_valid=0, rsp_dat=0, rsp_err=0, cmd_ready=1 (state IDLE), timeout count 0.
- States: IDLE, SETUP, BUS, RESP.
- IDLE: on cmd_valid & cmd_ready, latch we/adr/dat into we_o/adr_o/dat_o and go to SETUP.
- SETUP: one cycle. Address, we and data are stable with cyc_o=stb_o=0. Then go to BUS.
- BUS: cyc_o=stb_o=1, and we_o/adr_o/dat_o are held.
  - On a sampled ack_i: capture dat_i into rsp_dat for reads (0 for writes), set rsp_err=0, drop cyc_o/stb_o and we_o, set rsp_valid, go to RESP.
  - If ack_i is low and the count equals TIMEOUT−1: set rsp_dat all-ones, rsp_err=1, drop cyc_o/stb_o and we_o, set rsp_valid, go to RESP.
  - Otherwise increment the count.
- RESP: rsp_valid=1, and rsp_dat/rsp_err are stable. On rsp_ready, clear rsp_valid, clear the count and go to IDLE.
- No command pipelining: one outstanding transaction only. cmd_valid outside IDLE is ignored, with no side effect.
- adr_o/dat_o keep their last values after a cycle ends; no return to 0.
- Timeout counter width is clog2(TIMEOUT+1). It saturates by construction and never wraps.

## Timing
- Command accepted on edge N (IDLE).
- N+1: SETUP.
- N+2: BUS, with cyc_o/stb_o high.
- Zero-wait slave (ack in the first BUS cycle): rsp_valid high from N+3; cmd_ready high again from the cycle after the rsp_ready handshake.
- A slave with k wait cycles delays rsp_valid by k.
- Bus phase length is at most TIMEOUT cycles. An ack in the last allowed cycle wins over the timeout (rsp_err=0).
- ack_i is ignored outside BUS. A stray ack in SETUP, RESP or IDLE has no effect.
- rsp_valid and rsp_ready both high in RESP: the handshake completes on that edge, and cmd_ready asserts the next cycle.
- rst_i asserted mid-operation, in any state: outputs go to their reset values immediately (asynchronously), cyc_o/stb_o drop that instant, and the in-flight command and response are discarded.
- Reset release is synchronized externally; the block assumes it is deasserted synchronously to clk_i.

## Structure
- Shared package holds:
  - state encoding localparams (IDLE=2'd0, SETUP=2'd1, BUS=2'd2, RESP=2'd3)
  - WB_TIMEOUT_DEFAULT=15
  - the all-ones error data constant
- Single flat module with no sub-module. The timeout counter is inline.

## Test plan
- Write, then read back: write cmd adr=0 dat=0xA5 against the GPIO slave model, then a read of adr=0. Expect rsp_err=0 and rsp_dat=0xA5; exactly one cyc_o pulse per command; adr_o stable one cycle before stb_o.
- Registered-read slave, back-to-back reads: slave returns 0x3C for adr=2 with data registered from the address. Expect rsp_dat=0x3C, rsp_valid at N+3, and no stale value.
- Timeout with ack_i tied 0 and TIMEOUT=4: read adr=1. Expect stb_o high exactly 4 cycles, then rsp_err=1 and rsp_dat=0xFF.
- Ack on the last allowed cycle: slave acks on BUS cycle 4 with TIMEOUT=4. Expect rsp_err=0 and the captured data returned.
- Backpressure: rsp_ready held 0 for 5 cycles. Expect rsp_valid and rsp_dat stable throughout, cmd_ready=0 throughout, and a second cmd_valid not accepted until after the handshake.
- Reset during BUS: assert rst_i low mid-cycle. Expect cyc_o/stb_o=0 without waiting for a clock edge and no rsp_valid; after release, the next command completes normally.
